// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive path.
package eth_rx_pkg;
  localparam int RX_STATUS_W = 4;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef struct packed {
    logic err;
    logic eof;
    logic sof;
    logic valid;
  } rx_status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } rx_framer_state_t;
endpackage

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and emits one payload byte per beat
// with {err, eof, sof, valid}, delayed one beat so eof can ride on the last byte.
module gmii_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int MIN_PREAMBLE  = 2,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             gmii_rxd_i,
  input  logic                   gmii_rx_dv_i,
  input  logic                   gmii_rx_er_i,
  output logic [7:0]             data_o,
  output logic [RX_STATUS_W-1:0] status_o,
  output logic                   frame_err_o,
  output logic                   drop_o
);

  rx_framer_state_t r_state;
  logic [2:0]       r_pre_cnt;
  logic [10:0]      r_byte_cnt;
  logic             r_err_flag;
  logic             r_first;
  logic             r_hold_vld;
  logic             r_hold_first;
  logic [7:0]       r_hold_data;
  logic [7:0]       r_data;
  rx_status_t       r_status;
  logic             r_frame_err;
  logic             r_drop;

  logic             w_trunc;
  logic             w_eof_err;
  logic [10:0]      w_byte_cnt_inc;

  assign w_trunc        = (r_byte_cnt >= 11'(MAX_FRAME_LEN));
  assign w_eof_err      = r_err_flag | (r_byte_cnt < 11'(MIN_FRAME_LEN));
  assign w_byte_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;

  // Payload bytes carry no reset; their validity is tracked by r_hold_vld/r_status.
  always_ff @(posedge clk) begin
    if (r_state == ST_PAYLOAD) begin
      r_data <= r_hold_data;
      if (gmii_rx_dv_i && !w_trunc) r_hold_data <= gmii_rxd_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pre_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_err_flag   <= 1'b0;
      r_first      <= 1'b0;
      r_hold_vld   <= 1'b0;
      r_hold_first <= 1'b0;
      r_status     <= '0;
      r_frame_err  <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_status    <= '0;
      r_frame_err <= 1'b0;
      r_drop      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (gmii_rx_dv_i) begin
            if (gmii_rxd_i == PREAMBLE_BYTE && !gmii_rx_er_i) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= 3'd1;
            end else begin
              r_state <= ST_DROP;
              r_drop  <= 1'b1;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv_i) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b1;
          end else if (gmii_rx_er_i) begin
            r_state <= ST_DROP;
            r_drop  <= 1'b1;
          end else if (gmii_rxd_i == PREAMBLE_BYTE) begin
            if (r_pre_cnt != 3'd7) r_pre_cnt <= r_pre_cnt + 3'd1;
          end else if (gmii_rxd_i == SFD_BYTE && r_pre_cnt >= 3'(MIN_PREAMBLE)) begin
            r_state    <= ST_PAYLOAD;
            r_byte_cnt <= '0;
            r_err_flag <= 1'b0;
            r_first    <= 1'b1;
            r_hold_vld <= 1'b0;
          end else begin
            r_state <= ST_DROP;
            r_drop  <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (!gmii_rx_dv_i) begin
            // End of carrier: the held byte becomes the eof beat.
            if (r_hold_vld) begin
              r_status    <= '{err: w_eof_err, eof: 1'b1, sof: r_hold_first, valid: 1'b1};
              r_frame_err <= w_eof_err;
            end else begin
              r_drop <= 1'b1;
            end
            r_hold_vld <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_trunc) begin
            r_status    <= '{err: 1'b1, eof: 1'b1, sof: r_hold_first, valid: r_hold_vld};
            r_frame_err <= r_hold_vld;
            r_hold_vld  <= 1'b0;
            r_state     <= ST_DROP;
          end else begin
            if (r_hold_vld)
              r_status <= '{err: 1'b0, eof: 1'b0, sof: r_hold_first, valid: 1'b1};
            r_hold_vld   <= 1'b1;
            r_hold_first <= r_first;
            r_first      <= 1'b0;
            r_byte_cnt   <= w_byte_cnt_inc;
            if (gmii_rx_er_i) r_err_flag <= 1'b1;
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_o      = r_data;
  assign status_o    = r_status;
  assign frame_err_o = r_frame_err;
  assign drop_o      = r_drop;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: stimulus pushes expected beats, a monitor pops and compares.
module tb_gmii_rx_framer;
  localparam int MIN_FL = 64;
  localparam int MAX_FL = 1522;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic       dv  = 1'b0;
  logic       er  = 1'b0;
  logic [7:0] data_o;
  logic [3:0] status_o;
  logic       frame_err_o;
  logic       drop_o;

  always #4 clk = ~clk;

  gmii_rx_framer dut (
    .clk          (clk),
    .rst          (rst),
    .gmii_rxd_i   (rxd),
    .gmii_rx_dv_i (dv),
    .gmii_rx_er_i (er),
    .data_o       (data_o),
    .status_o     (status_o),
    .frame_err_o  (frame_err_o),
    .drop_o       (drop_o)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] st;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   drop_seen = 0;
  int   drop_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (drop_o === 1'b1) drop_seen++;
      if (status_o[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data %02h status %b at cycle %0d, required no beat",
                   data_o, status_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e.d || status_o !== e.st || cyc != e.cyc) begin
            errors++;
            $display("FAIL beat: got data %02h status %b cycle %0d, required data %02h status %b cycle %0d",
                     data_o, status_o, cyc, e.d, e.st, e.cyc);
          end
        end
      end
      if (frame_err_o === 1'b1 || (status_o[0] && status_o[2] && status_o[3])) begin
        checks++;
        if (frame_err_o !== (status_o[0] && status_o[2] && status_o[3])) begin
          errors++;
          $display("FAIL frame_err_pulse: got frame_err %b with status %b, required frame_err on eof-err beat only",
                   frame_err_o, status_o);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    @(negedge clk);
    rxd = d;
    dv  = v;
    er  = e;
  endtask

  // Byte driven on this half-cycle is captured next edge and leaves the hold one edge later.
  task automatic push(input logic [7:0] d, input logic [3:0] st);
    exp_t x;
    x.d = d;
    x.st = st;
    x.cyc = cyc + 2;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input int npre, input int n, input int er_idx, input int tag);
    int  nk;
    bit  bad;
    logic [7:0] b;
    nk  = (n > MAX_FL) ? MAX_FL : n;
    bad = (n > MAX_FL) || (n < MIN_FL) || (er_idx >= 0 && er_idx < nk);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      b = 8'(i + tag);
      drive(b, 1'b1, i == er_idx);
      if (i < nk) push(b, {(i == nk - 1) && bad, i == nk - 1, i == 0, 1'b1});
    end
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_end(input string name, input int exp_drops);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d beats still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (drop_seen - drop_base != exp_drops) begin
      errors++;
      $display("FAIL %s_drops: got %0d drop pulses, required %0d", name, drop_seen - drop_base, exp_drops);
    end
    drop_base = drop_seen;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if (status_o !== 4'b0000 || frame_err_o !== 1'b0 || drop_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got status %b frame_err %b drop %b, required 0 0 0",
               status_o, frame_err_o, drop_o);
    end
    rst = 1'b1;
    repeat (2) drive(8'h00, 1'b0, 1'b0);

    // Two legal frames back to back with one idle cycle; second has rx_er on byte 10.
    send_frame(7, 64, -1, 0);
    send_frame(7, 64, 10, 8'h40);
    check_end("good_and_er", 0);

    send_frame(7, 20, -1, 8'h80);
    check_end("runt20", 0);

    send_frame(7, 63, -1, 8'h10);
    check_end("runt63", 0);

    send_frame(2, 1, -1, 8'hA7);
    check_end("single_byte_min_pre", 0);

    send_frame(7, 0, -1, 0);
    check_end("zero_byte", 1);

    // One 0x55 then SFD is too short; the next frame follows with one idle cycle.
    drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(8'(i), 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    send_frame(7, 64, -1, 8'h33);
    check_end("short_pre", 1);

    send_frame(7, 1600, -1, 0);
    check_end("oversize", 0);

    // Reset asserted while payload byte 30 is on the wire.
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      drive(8'(i), 1'b1, 1'b0);
      if (i < 29) push(8'(i), {1'b0, 1'b0, i == 0, 1'b1});
    end
    @(negedge clk);
    rxd = 8'd30;
    rst = 1'b0;
    #1;
    checks++;
    if (status_o !== 4'b0000 || frame_err_o !== 1'b0 || drop_o !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got status %b frame_err %b drop %b, required 0 0 0",
               status_o, frame_err_o, drop_o);
    end
    drive(8'd31, 1'b1, 1'b0);
    @(negedge clk);
    rxd = 8'd32;
    rst = 1'b1;
    for (int i = 33; i < 60; i++) drive(8'(i), 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    send_frame(7, 64, -1, 8'hC0);
    check_end("after_reset", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
